// File: rtl/cpu_dmem_pkg.sv
// Shared encodings for the data-memory sequencer: access sizes, FSM states and
// the alignment rule applied when a request is accepted.
package cpu_dmem_pkg;

   localparam logic [1:0] MEM_SIZE_B = 2'b00;
   localparam logic [1:0] MEM_SIZE_S = 2'b01;
   localparam logic [1:0] MEM_SIZE_L = 2'b10;

   localparam logic [1:0] DSEQ_IDLE = 2'd0;
   localparam logic [1:0] DSEQ_BUS  = 2'd1;
   localparam logic [1:0] DSEQ_RESP = 2'd2;

   // Longs only need bus-word alignment, so a 16-bit bus accepts them on any even address.
   function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr,
                                           input logic bus32);
      case (size)
         MEM_SIZE_B: return 1'b0;
         MEM_SIZE_S: return addr[0];
         MEM_SIZE_L: return bus32 ? (|addr) : addr[0];
         default:    return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/cpu_dmem_lanes.sv
// Big-endian lane steering: write data/sel for the beat being issued and
// read-data extraction/assembly for the beat being acknowledged.
module cpu_dmem_lanes
   import cpu_dmem_pkg::*;
#(
   parameter int BUS_WIDTH = 16
) (
   input  logic [1:0]             wr_size_i,
   input  logic [1:0]             wr_addr_i,
   input  logic                   wr_beat_i,
   input  logic [31:0]            wdata_i,
   output logic [BUS_WIDTH-1:0]   dat_o,
   output logic [BUS_WIDTH/8-1:0] sel_o,
   input  logic [1:0]             rd_size_i,
   input  logic [1:0]             rd_addr_i,
   input  logic [BUS_WIDTH-1:0]   rd_bus_i,
   input  logic [31:0]            rd_acc_i,
   output logic [31:0]            rd_acc_o
);

   localparam int NB = BUS_WIDTH / 8;
   localparam logic [1:0] OFF_MASK = 2'(NB - 1);

   function automatic logic [2:0] beat_bytes(input logic [1:0] size);
      case (size)
         MEM_SIZE_B: return 3'd1;
         MEM_SIZE_S: return 3'd2;
         default:    return 3'(NB);
      endcase
   endfunction

   // Number of byte lanes below the item: the lowest address sits on the top lane.
   function automatic logic [2:0] lanes_below(input logic [1:0] size, input logic [1:0] addr);
      return 3'(NB) - {1'b0, addr & OFF_MASK} - beat_bytes(size);
   endfunction

   function automatic logic [31:0] beat_mask(input logic [1:0] size);
      case (beat_bytes(size))
         3'd1:    return 32'h0000_00FF;
         3'd2:    return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   logic [31:0] item;
   logic [2:0]  wsh;
   logic [2:0]  rsh;
   logic [3:0]  sel_base;
   logic [31:0] lane_val;

   always_comb begin
      item = wdata_i;
      if (NB == 2 && wr_size_i == MEM_SIZE_L && !wr_beat_i) item = wdata_i >> 16;
      wsh = lanes_below(wr_size_i, wr_addr_i);
      case (beat_bytes(wr_size_i))
         3'd1:    sel_base = 4'b0001;
         3'd2:    sel_base = 4'b0011;
         default: sel_base = 4'b1111;
      endcase
      dat_o = BUS_WIDTH'(item & beat_mask(wr_size_i)) << {wsh, 3'b000};
      sel_o = NB'(sel_base << wsh);
   end

   // Split longs shift earlier beats up so the first beat ends in the MSBs.
   always_comb begin
      rsh      = lanes_below(rd_size_i, rd_addr_i);
      lane_val = 32'(rd_bus_i >> {rsh, 3'b000}) & beat_mask(rd_size_i);
      rd_acc_o = (NB == 2 && rd_size_i == MEM_SIZE_L) ? ((rd_acc_i << 16) | lane_val) : lane_val;
   end

endmodule

// File: rtl/cpu_dmem_sequencer.sv
// Data-memory sequencer: splits one load/store into Wishbone beats, tracks
// ack/err with a per-beat timeout and returns one tagged response.
module cpu_dmem_sequencer
   import cpu_dmem_pkg::*;
#(
   parameter int BUS_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_we_i,
   input  logic [1:0]             req_size_i,
   input  logic [31:0]            req_addr_i,
   input  logic [31:0]            req_wdata_i,
   input  logic [3:0]             req_tag_i,
   input  logic                   flush_i,
   output logic                   stall_o,
   output logic                   resp_valid_o,
   output logic                   resp_err_o,
   output logic [31:0]            resp_rdata_o,
   output logic [3:0]             resp_tag_o,
   output logic                   resp_we_o,
   output logic [31:0]            dmem_address_o,
   output logic [BUS_WIDTH-1:0]   dmem_data_o,
   input  logic [BUS_WIDTH-1:0]   dmem_data_i,
   output logic [BUS_WIDTH/8-1:0] dmem_sel_o,
   output logic                   dmem_we_o,
   output logic                   dmem_stb_o,
   output logic                   dmem_cyc_o,
   input  logic                   dmem_ack_i,
   input  logic                   dmem_err_i
);

   localparam int NB = BUS_WIDTH / 8;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [1:0]           state_q, state_d;
   logic                 we_q, we_d;
   logic [1:0]           size_q, size_d;
   logic [31:0]          addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           tag_q, tag_d;
   logic                 beat_q, beat_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic                 flush_q, flush_d;
   logic                 err_q, err_d;
   logic [31:0]          rdata_q, rdata_d;
   logic                 cyc_q, cyc_d;
   logic                 stb_q, stb_d;
   logic                 bus_we_q, bus_we_d;
   logic [BUS_WIDTH-1:0] dat_q, dat_d;
   logic [NB-1:0]        sel_q, sel_d;

   logic                 long_split;
   logic                 tmo_hit;
   logic [BUS_WIDTH-1:0] wr_dat;
   logic [NB-1:0]        wr_sel;
   logic [31:0]          rd_acc;

   assign long_split = (NB == 2) && (size_q == MEM_SIZE_L);
   assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // Write side sees the next-beat request so data/sel can be registered with cyc/stb.
   cpu_dmem_lanes #(.BUS_WIDTH(BUS_WIDTH)) u_lanes (
      .wr_size_i (size_d),
      .wr_addr_i (addr_d[1:0]),
      .wr_beat_i (beat_d),
      .wdata_i   (wdata_d),
      .dat_o     (wr_dat),
      .sel_o     (wr_sel),
      .rd_size_i (size_q),
      .rd_addr_i (addr_q[1:0]),
      .rd_bus_i  (dmem_data_i),
      .rd_acc_i  (rdata_q),
      .rd_acc_o  (rd_acc)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      tag_d   = tag_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      flush_d = flush_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      case (state_q)
         DSEQ_IDLE: if (req_valid_i) begin
            we_d    = req_we_i;
            size_d  = req_size_i;
            addr_d  = req_addr_i;
            wdata_d = req_wdata_i;
            tag_d   = req_tag_i;
            beat_d  = 1'b0;
            tmo_d   = '0;
            flush_d = 1'b0;
            rdata_d = '0;
            err_d   = req_misaligned(req_size_i, req_addr_i[1:0], NB == 4);
            if (err_d) begin
               state_d = DSEQ_RESP;
            end else begin
               state_d = DSEQ_BUS;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
            end
         end
         DSEQ_BUS: begin
            if (flush_i) flush_d = 1'b1;
            if (dmem_err_i || (!dmem_ack_i && tmo_hit)) begin
               err_d   = 1'b1;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               state_d = DSEQ_RESP;
            end else if (dmem_ack_i) begin
               rdata_d = we_q ? 32'h0 : rd_acc;
               tmo_d   = '0;
               if (long_split && !beat_q) begin
                  beat_d = 1'b1;
                  addr_d = addr_q + 32'(NB);
               end else begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  state_d = DSEQ_RESP;
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = DSEQ_IDLE;
      endcase
   end

   always_comb begin
      bus_we_d = cyc_d & we_d;
      dat_d    = (cyc_d && we_d) ? wr_dat : '0;
      sel_d    = cyc_d ? wr_sel : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= DSEQ_IDLE;
         we_q     <= 1'b0;
         size_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         tag_q    <= '0;
         beat_q   <= 1'b0;
         tmo_q    <= '0;
         flush_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         bus_we_q <= 1'b0;
         dat_q    <= '0;
         sel_q    <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         tag_q    <= tag_d;
         beat_q   <= beat_d;
         tmo_q    <= tmo_d;
         flush_q  <= flush_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         cyc_q    <= cyc_d;
         stb_q    <= stb_d;
         bus_we_q <= bus_we_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
      end
   end

   assign req_ready_o    = (state_q == DSEQ_IDLE);
   assign stall_o        = (state_q != DSEQ_IDLE);
   assign resp_valid_o   = (state_q == DSEQ_RESP) && !flush_q;
   assign resp_err_o     = resp_valid_o & err_q;
   assign resp_rdata_o   = resp_valid_o ? rdata_q : 32'h0;
   assign resp_tag_o     = resp_valid_o ? tag_q : 4'h0;
   assign resp_we_o      = resp_valid_o & we_q;
   assign dmem_address_o = addr_q;
   assign dmem_data_o    = dat_q;
   assign dmem_sel_o     = sel_q;
   assign dmem_we_o      = bus_we_q;
   assign dmem_stb_o     = stb_q;
   assign dmem_cyc_o     = cyc_q;

endmodule

// File: tb/tb_cpu_dmem_sequencer.sv
// Bench for cpu_dmem_sequencer: a 16-bit and a 32-bit instance share one
// byte-addressed memory slave; responses are predicted from that memory.
module tb_cpu_dmem_sequencer;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i;
   logic        v16, v32;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_tag;
   logic        flush, ack, berr;
   logic [31:0] bus_rd;
   bit          cur32;

   logic rdy16, stall16, rv16, re16, rw16, we16, stb16, cyc16;
   logic rdy32, stall32, rv32, re32, rw32, we32, stb32, cyc32;
   logic [31:0] rd16, rd32, adr16, adr32, dat32;
   logic [3:0]  rt16, rt32, sel32;
   logic [15:0] dat16;
   logic [1:0]  sel16;

   cpu_dmem_sequencer #(.BUS_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut16 (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(v16), .req_ready_o(rdy16), .req_we_i(req_we),
      .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_tag_i(req_tag),
      .flush_i(flush), .stall_o(stall16), .resp_valid_o(rv16), .resp_err_o(re16),
      .resp_rdata_o(rd16), .resp_tag_o(rt16), .resp_we_o(rw16), .dmem_address_o(adr16),
      .dmem_data_o(dat16), .dmem_data_i(bus_rd[15:0]), .dmem_sel_o(sel16), .dmem_we_o(we16),
      .dmem_stb_o(stb16), .dmem_cyc_o(cyc16), .dmem_ack_i(ack), .dmem_err_i(berr));

   cpu_dmem_sequencer #(.BUS_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut32 (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(v32), .req_ready_o(rdy32), .req_we_i(req_we),
      .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_tag_i(req_tag),
      .flush_i(flush), .stall_o(stall32), .resp_valid_o(rv32), .resp_err_o(re32),
      .resp_rdata_o(rd32), .resp_tag_o(rt32), .resp_we_o(rw32), .dmem_address_o(adr32),
      .dmem_data_o(dat32), .dmem_data_i(bus_rd), .dmem_sel_o(sel32), .dmem_we_o(we32),
      .dmem_stb_o(stb32), .dmem_cyc_o(cyc32), .dmem_ack_i(ack), .dmem_err_i(berr));

   wire        o_rdy   = cur32 ? rdy32 : rdy16;
   wire        o_stall = cur32 ? stall32 : stall16;
   wire        o_rv    = cur32 ? rv32 : rv16;
   wire        o_re    = cur32 ? re32 : re16;
   wire        o_rw    = cur32 ? rw32 : rw16;
   wire [31:0] o_rd    = cur32 ? rd32 : rd16;
   wire [3:0]  o_rt    = cur32 ? rt32 : rt16;
   wire [31:0] o_adr   = cur32 ? adr32 : adr16;
   wire [31:0] o_dat   = cur32 ? dat32 : {16'h0, dat16};
   wire [3:0]  o_sel   = cur32 ? sel32 : {2'b00, sel16};
   wire        o_we    = cur32 ? we32 : we16;
   wire        o_stb   = cur32 ? stb32 : stb16;
   wire        o_cyc   = cur32 ? cyc32 : cyc16;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   logic [7:0] mem [logic [31:0]];

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   logic [31:0] b_adr [4];
   logic [31:0] b_dat [4];
   logic [3:0]  b_sel [4];
   logic [31:0] last_rd;
   logic [3:0]  last_tag;
   logic        last_err, last_we;

   task automatic run_txn(input bit w32, input bit we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] tag, input int wait_c,
                          input int err_beat, input bit hang, input bit flush_en);
      int nb, nbytes, align, beats, exp_beats, exp_stb, n_resp, resp_cyc, issued, wcnt;
      int stb_cyc, cyc_cyc, written;
      bit mis, exp_err, done;
      logic [31:0] exp_rd, base, word, lm;
      cur32  = w32;
      nb     = w32 ? 4 : 2;
      nbytes = (size == 2'd2) ? 4 : (size == 2'd1) ? 2 : 1;
      align  = (nbytes < nb) ? nbytes : nb;
      mis    = (size == 2'd3) || (addr % align != 0);
      beats  = mis ? 0 : (nbytes + nb - 1) / nb;
      exp_rd = 0;
      for (int i = 0; i < nbytes; i++) exp_rd = (exp_rd << 8) | 32'(mem_rd(addr + 32'(i)));
      exp_err = 1'b1; exp_beats = 0; exp_stb = 0;
      if (!mis) begin
         if (hang) begin
            exp_beats = 1; exp_stb = TMO;
         end else if (err_beat >= 0 && err_beat < beats) begin
            exp_beats = err_beat + 1; exp_stb = exp_beats * (wait_c + 1);
         end else begin
            exp_beats = beats; exp_stb = beats * (wait_c + 1); exp_err = 1'b0;
         end
      end
      n_resp = 0; resp_cyc = -1; issued = 0; wcnt = 0; stb_cyc = 0; cyc_cyc = 0; written = 0;
      done = 1'b0;
      @(negedge clk);
      chk("idle_ready", o_rdy, 1);
      req_we = we; req_size = size; req_addr = addr; req_wdata = wdata; req_tag = tag;
      if (w32) v32 = 1'b1; else v16 = 1'b1;
      for (int n = 1; n <= 300 && !done; n++) begin
         @(posedge clk);
         @(negedge clk);
         v16 = 1'b0; v32 = 1'b0; ack = 1'b0; berr = 1'b0; bus_rd = $urandom;
         flush = flush_en && (n == 1) && !mis;
         if (o_rdy) done = 1'b1;
         else begin
            chk("stall", o_stall, 1);
            if (o_rv) begin
               n_resp++; resp_cyc = n;
               last_err = o_re; last_rd = o_rd; last_tag = o_rt; last_we = o_rw;
            end
            if (o_cyc) cyc_cyc++;
            if (o_stb) begin
               stb_cyc++;
               if (wcnt == 0) begin
                  if (issued < 4) begin
                     b_adr[issued] = o_adr; b_dat[issued] = o_dat; b_sel[issued] = o_sel;
                  end
                  issued++;
                  chk("bus_we", o_we, we);
                  lm = 0;
                  for (int l = 0; l < 4; l++) if (o_sel[l]) lm[8*l +: 8] = 8'hFF;
                  chk("unused_lanes", we ? (o_dat & ~lm) : o_dat, 0);
               end
               if (!hang && wcnt == wait_c) begin
                  wcnt = 0;
                  if (issued - 1 == err_beat) berr = 1'b1;
                  else begin
                     ack  = 1'b1;
                     base = o_adr & ~32'(nb - 1);
                     if (we) begin
                        for (int l = 0; l < nb; l++)
                           if (o_sel[l]) begin
                              mem[base + 32'(nb - 1 - l)] = o_dat[8*l +: 8];
                              written++;
                           end
                     end else begin
                        word = 0;
                        for (int i = 0; i < nb; i++) word = (word << 8) | 32'(mem_rd(base + 32'(i)));
                        bus_rd = word;
                     end
                  end
               end else wcnt++;
            end
         end
      end
      flush = 1'b0; ack = 1'b0; berr = 1'b0;
      chk("txn_done", done, 1);
      chk("resp_count", n_resp, (flush_en && !mis) ? 0 : 1);
      if (n_resp == 1) begin
         chk("resp_cycle", resp_cyc, mis ? 1 : exp_stb + 1);
         chk("resp_err", last_err, exp_err);
         chk("resp_tag", last_tag, tag);
         chk("resp_we", last_we, we);
         if (!we && !exp_err) chk("resp_rdata", last_rd, exp_rd);
      end
      chk("beats", issued, exp_beats);
      chk("stb_cycles", stb_cyc, exp_stb);
      chk("cyc_cycles", cyc_cyc, exp_stb);
      if (we && !exp_err) begin
         chk("st_bytes", written, nbytes);
         for (int i = 0; i < nbytes; i++)
            chk("st_mem", mem_rd(addr + 32'(i)), (wdata >> (8 * (nbytes - 1 - i))) & 32'hFF);
      end
   endtask

   initial begin
      int nr;
      rst_i = 1'b1; v16 = 1'b0; v32 = 1'b0; req_we = 1'b0; req_size = 2'd0; req_addr = 0;
      req_wdata = 0; req_tag = 0; flush = 1'b0; ack = 1'b0; berr = 1'b0; bus_rd = 0; cur32 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cyc16", {cyc16, stb16, we16, rv16, stall16}, 0);
      chk("rst_cyc32", {cyc32, stb32, we32, rv32, stall32}, 0);
      chk("rst_bus16", {adr16, dat16, sel16}, 0);
      chk("rst_ready", {rdy16, rdy32}, 2'b11);
      rst_i = 1'b0;

      mem[32'h2000] = 8'hAB; mem[32'h2001] = 8'hCD;
      mem[32'h3000] = 8'hDE; mem[32'h3001] = 8'hAD; mem[32'h3002] = 8'hBE; mem[32'h3003] = 8'hEF;
      mem[32'h4000] = 8'h01; mem[32'h4001] = 8'h23; mem[32'h4002] = 8'h45; mem[32'h4003] = 8'h67;

      run_txn(0, 1, 2'd2, 32'h1000, 32'h1122_3344, 4'h3, 0, -1, 0, 0);
      chk("st_l_adr0", b_adr[0], 32'h1000);
      chk("st_l_dat0", b_dat[0], 32'h1122);
      chk("st_l_sel0", b_sel[0], 4'b0011);
      chk("st_l_adr1", b_adr[1], 32'h1002);
      chk("st_l_dat1", b_dat[1], 32'h3344);
      run_txn(0, 0, 2'd0, 32'h2001, 0, 4'h9, 0, -1, 0, 0);
      chk("ld_b_sel", b_sel[0], 4'b0001);
      chk("ld_b_data", last_rd, 32'h0000_00CD);
      run_txn(0, 0, 2'd2, 32'h3000, 0, 4'h5, 3, -1, 0, 0);
      chk("ld_l_data", last_rd, 32'hDEAD_BEEF);
      run_txn(0, 0, 2'd2, 32'h3000, 0, 4'h6, 0, -1, 1, 0);
      chk("tmo_err", last_err, 1);
      run_txn(0, 1, 2'd2, 32'h1100, 32'hCAFE_F00D, 4'h7, 0, 0, 0, 0);
      chk("berr_err", last_err, 1);
      run_txn(0, 0, 2'd1, 32'h3001, 0, 4'h2, 0, -1, 0, 0);
      chk("mis_err", last_err, 1);
      run_txn(0, 0, 2'd2, 32'h3000, 0, 4'h1, 1, -1, 0, 1);
      run_txn(1, 0, 2'd2, 32'h4000, 0, 4'hA, 0, -1, 0, 0);
      chk("w32_l_sel", b_sel[0], 4'b1111);
      chk("w32_l_data", last_rd, 32'h0123_4567);
      run_txn(1, 1, 2'd0, 32'h4002, 32'h0000_005A, 4'hB, 0, -1, 0, 0);
      chk("w32_b_sel", b_sel[0], 4'b0010);
      chk("w32_b_dat", b_dat[0], 32'h0000_5A00);

      // Reset in the middle of a beat on the 32-bit instance.
      cur32 = 1'b1;
      @(negedge clk);
      req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4000; v32 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v32 = 1'b0;
      chk("rst_mid_pre", o_cyc, 1);
      rst_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_cyc", {o_cyc, o_stb}, 0);
      rst_i = 1'b0;
      nr = 0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
         if (o_rv) nr++;
      end
      chk("rst_mid_noresp", nr, 0);
      chk("rst_mid_ready", o_rdy, 1);

      for (int t = 0; t < 60; t++) begin
         int r;
         logic [1:0] sz;
         r  = $urandom_range(0, 9);
         sz = (r == 9) ? 2'd3 : 2'(r % 3);
         run_txn(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), sz,
                 32'h8000 + 32'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : -1,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
